issue_sequencer: RTL and testbench
==================================

# issue_sequencer

Single-issue dispatch controller sitting between instruction fetch and the execution units. It latches one fetched instruction, drives the instruction-class decoder (its 32-bit `Input` and `Enabled`), and samples the decoder's one-hot class outputs. It then hands the instruction to the ALU, branch unit or load/store unit with valid/ready handshakes. It also drains outstanding memory operations for FENCE and raises trap requests for SYSTEM and illegal encodings.

## Interface
Parameters:
- MAX_MEM_OUTSTANDING, 4, maximum accepted-but-not-completed LSU operations; legal range 1..15.

Ports:
- clk  in  1  clock. One clock domain; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- inst_valid  in  1  fetch offers an instruction.
- inst_data  in  32  offered instruction word.
- inst_ready  out  1  sequencer accepts `inst_data` this cycle.
- dec_input  out  32  registered instruction `inst_q`; drives decoder `Input`.
- dec_enable  out  1  drives decoder `Enabled`.
- dec_alu, dec_control, dec_mem, dec_fence, dec_system, dec_error  in  1 each  decoder class outputs, combinational on `dec_input`.
- issue_inst  out  32  equals `inst_q`; broadcast to all units.
- alu_valid  out  1  ALU issue request.
- alu_ready  in  1  ALU accepts the issue.
- br_valid  out  1  branch-unit issue request.
- br_ready  in  1  branch unit accepts the issue.
- br_done  in  1  single-cycle pulse: branch resolved (redirect or fall-through).
- lsu_valid  out  1  LSU issue request.
- lsu_ready  in  1  LSU accepts the issue.
- lsu_done  in  1  single-cycle pulse: one memory operation completed.
- trap_req  out  1  trap request.
- trap_cause  out  2  01 = illegal instruction, 10 = SYSTEM; 00 when `trap_req` is low.
- trap_ack  in  1  trap handler accepts the trap.
- busy  out  1  high when state ≠ IDLE or `mem_cnt` ≠ 0.

## Operation
States and transitions:
- IDLE:
  - `inst_ready`=1 (forced 0 while `rst` is high).
  - On `inst_valid`: `inst_q` ← `inst_data`, go to DISPATCH.
- DISPATCH:
  - `dec_enable`=1. Class priority: error > system > fence > control > mem > alu.
  - No class bit set: treated as error.
  - error: `trap_req`=1, `trap_cause`=01 → TRAP.
  - system: `trap_req`=1, `trap_cause`=10 → TRAP.
  - fence: → FENCE_DRAIN. No unit handshake.
  - control: `br_valid`=1; on `br_ready` → WAIT_BR.
  - mem: `lsu_valid`=1 only if `mem_cnt` < MAX_MEM_OUTSTANDING (stall otherwise); on `lsu_ready` → IDLE.
  - alu: `alu_valid`=1; on `alu_ready` → IDLE.
- WAIT_BR: on `br_done` → IDLE. Blocks all further issue.
- FENCE_DRAIN: stay until `mem_cnt`==0, then → IDLE. Check uses the registered count.
- TRAP:
  - Hold `trap_req` and `trap_cause` stable until `trap_ack`, then → IDLE.
  - `trap_ack` received in any other state is ignored.

Rules:
- `mem_cnt` width is $clog2(MAX_MEM_OUTSTANDING+1).
  - +1 on an `lsu_valid`&`lsu_ready` handshake; −1 on `lsu_done`.
  - Handshake and `lsu_done` in the same cycle: count unchanged.
  - `lsu_done` at count 0: ignored; count stays 0, no underflow.
- Valid outputs are Moore-style: decoded from state plus the decoder class inputs. Once raised, a valid stays high until its ready; it never drops while waiting.
- `br_done` outside WAIT_BR is ignored.
- Reset value of every output: `inst_ready` 0 while `rst` is high, 1 after release. All valids 0, `trap_req` 0, `trap_cause` 00, `dec_enable` 0, `dec_input`/`issue_inst` 0, `busy` 0.
- Reset asserted mid-operation: state → IDLE, `mem_cnt` → 0, `inst_q` → 0 immediately (asynchronous). Pending handshakes are abandoned.

## Timing
- Instruction accepted in cycle N; unit valid asserted in N+1.
- Ready in N+1 → IDLE in N+2, which accepts the next instruction. Peak throughput is one instruction per 2 cycles.
- Branch: IDLE is re-entered on the cycle after `br_done`.
- Fence with `mem_cnt`==0: DISPATCH in N+1, FENCE_DRAIN in N+2, IDLE in N+3.
- Trap: `trap_req` first high in N+1; IDLE on the cycle after `trap_ack`.

## Structure
- Package `issue_pkg`:
  - state enum IDLE/DISPATCH/WAIT_BR/FENCE_DRAIN/TRAP.
  - `TRAP_ILLEGAL`=2'b01, `TRAP_SYSTEM`=2'b10.
  - RV32I opcode constants (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 0001111, 1110011) for the bench.
- Sub-module `mem_outstanding_counter`: saturating up/down counter with `full`/`empty` flags, parameterised by MAX_MEM_OUTSTANDING.
- The decoder is instantiated by the parent, not inside this block.

## Test plan
- ADDI 0x00500093, `alu_ready` held 1 → `alu_valid` high exactly in N+1; `inst_ready` high again in N+2.
- BEQ 0x00000463, `br_ready`=1, `br_done` 5 cycles later → `inst_ready` stays 0 until the cycle after `br_done`.
- Four LW 0x0000A103 with no `lsu_done`, then a fifth LW → fifth `lsu_valid` held 0, `busy`=1. One `lsu_done` → fifth issues next cycle.
- Two outstanding LW, then FENCE 0x0FF0000F → FSM stays in FENCE_DRAIN until the second `lsu_done`; IDLE one cycle after `mem_cnt` reaches 0.
- ECALL 0x00000073 → `trap_req`=1, `trap_cause`=10 held for 3 cycles until `trap_ack`. Word 0x00000000 → `trap_cause`=01.
- `rst` pulsed during WAIT_BR with `mem_cnt`=2 → same-cycle return to IDLE, `mem_cnt`=0, all valids 0.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared types and constants for the single-issue dispatch sequencer.
package issue_pkg;

  typedef enum logic [2:0] {
    Idle,
    Dispatch,
    WaitBr,
    FenceDrain,
    Trap
  } state_e;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_SYSTEM  = 2'b10;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/mem_outstanding_counter.sv
// Up/down count of accepted-but-incomplete LSU operations, clamped to 0..MAX_MEM_OUTSTANDING.
module mem_outstanding_counter #(
  parameter int unsigned MAX_MEM_OUTSTANDING = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       inc,
  input  logic                                       dec,
  output logic [$clog2(MAX_MEM_OUTSTANDING+1)-1:0]   count,
  output logic                                       full,
  output logic                                       empty
);

  localparam int unsigned W = $clog2(MAX_MEM_OUTSTANDING + 1);
  localparam logic [W-1:0] MaxCnt = W'(MAX_MEM_OUTSTANDING);

  logic [W-1:0] count_q, count_d;
  logic         up, down;

  assign full  = (count_q == MaxCnt);
  assign empty = (count_q == '0);
  assign count = count_q;

  always_comb begin
    // A completion with nothing outstanding is spurious and dropped.
    up      = inc & ~full;
    down    = dec & ~empty;
    count_d = count_q;
    if (up && !down) begin
      count_d = count_q + W'(1);
    end else if (down && !up) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/issue_sequencer.sv
// Latches one instruction, classifies it via the external decoder and hands it to ALU,
// branch unit or LSU; drains memory ops on FENCE and raises traps for SYSTEM/illegal.
module issue_sequencer
  import issue_pkg::*;
#(
  parameter int unsigned MAX_MEM_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst_data,
  output logic        inst_ready,
  output logic [31:0] dec_input,
  output logic        dec_enable,
  input  logic        dec_alu,
  input  logic        dec_control,
  input  logic        dec_mem,
  input  logic        dec_fence,
  input  logic        dec_system,
  input  logic        dec_error,
  output logic [31:0] issue_inst,
  output logic        alu_valid,
  input  logic        alu_ready,
  output logic        br_valid,
  input  logic        br_ready,
  input  logic        br_done,
  output logic        lsu_valid,
  input  logic        lsu_ready,
  input  logic        lsu_done,
  output logic        trap_req,
  output logic [1:0]  trap_cause,
  input  logic        trap_ack,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(MAX_MEM_OUTSTANDING + 1);

  state_e          state_q, state_d;
  logic [31:0]     inst_q;
  logic [1:0]      cause_q, cause_d;
  logic [CntW-1:0] mem_cnt;
  logic            mem_full, mem_empty;
  logic            cls_err, cls_sys, cls_fence, cls_ctrl, cls_mem;

  mem_outstanding_counter #(
    .MAX_MEM_OUTSTANDING(MAX_MEM_OUTSTANDING)
  ) u_mem_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (lsu_valid & lsu_ready),
    .dec  (lsu_done),
    .count(mem_cnt),
    .full (mem_full),
    .empty(mem_empty)
  );

  // Fixed priority; an instruction the decoder claims no class for is illegal.
  always_comb begin
    cls_err   = dec_error |
                ~(dec_alu | dec_control | dec_mem | dec_fence | dec_system);
    cls_sys   = ~cls_err & dec_system;
    cls_fence = ~cls_err & ~dec_system & dec_fence;
    cls_ctrl  = ~cls_err & ~dec_system & ~dec_fence & dec_control;
    cls_mem   = ~cls_err & ~dec_system & ~dec_fence & ~dec_control & dec_mem;
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    inst_ready = 1'b0;
    dec_enable = 1'b0;
    alu_valid  = 1'b0;
    br_valid   = 1'b0;
    lsu_valid  = 1'b0;
    trap_req   = 1'b0;
    trap_cause = TRAP_NONE;
    unique case (state_q)
      Idle: begin
        inst_ready = ~rst;
        if (inst_valid) state_d = Dispatch;
      end
      Dispatch: begin
        dec_enable = 1'b1;
        if (cls_err || cls_sys) begin
          trap_req   = 1'b1;
          trap_cause = cls_err ? TRAP_ILLEGAL : TRAP_SYSTEM;
          cause_d    = trap_cause;
          state_d    = Trap;
        end else if (cls_fence) begin
          state_d = FenceDrain;
        end else if (cls_ctrl) begin
          br_valid = 1'b1;
          if (br_ready) state_d = WaitBr;
        end else if (cls_mem) begin
          // Count can only fall while stalled here, so a raised valid never drops.
          lsu_valid = ~mem_full;
          if (lsu_valid && lsu_ready) state_d = Idle;
        end else begin
          alu_valid = 1'b1;
          if (alu_ready) state_d = Idle;
        end
      end
      WaitBr: begin
        if (br_done) state_d = Idle;
      end
      FenceDrain: begin
        if (mem_empty) state_d = Idle;
      end
      Trap: begin
        trap_req   = 1'b1;
        trap_cause = cause_q;
        if (trap_ack) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= Idle;
      cause_q <= TRAP_NONE;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q == Idle && inst_valid) inst_q <= inst_data;
    end
  end

  assign dec_input  = inst_q;
  assign issue_inst = inst_q;
  assign busy       = (state_q != Idle) | ~mem_empty;

endmodule

// File: tb/tb_issue_sequencer.sv
// Randomized and directed checks of issue_sequencer against an instruction-lifecycle model.
module tb_issue_sequencer;
  import issue_pkg::*;

  localparam int unsigned MAX_OUT = 4;

  localparam logic [31:0] W_ADDI  = 32'h00500093;
  localparam logic [31:0] W_ADD   = 32'h002081B3;
  localparam logic [31:0] W_BEQ   = 32'h00000463;
  localparam logic [31:0] W_JAL   = 32'h0080006F;
  localparam logic [31:0] W_LW    = 32'h0000A103;
  localparam logic [31:0] W_SW    = 32'h0020A023;
  localparam logic [31:0] W_FENCE = 32'h0FF0000F;
  localparam logic [31:0] W_ECALL = 32'h00000073;
  localparam logic [31:0] W_ZERO  = 32'h00000000;
  localparam logic [31:0] W_ONES  = 32'hFFFFFFFF;

  localparam int K_ALU = 0, K_BR = 1, K_MEM = 2, K_FENCE = 3, K_SYS = 4, K_ILL = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid, alu_ready, br_ready, br_done, lsu_ready, lsu_done, trap_ack;
  logic [31:0] inst_data;
  logic        inst_ready, dec_enable, alu_valid, br_valid, lsu_valid, trap_req, busy;
  logic [31:0] dec_input, issue_inst;
  logic        dec_alu, dec_control, dec_mem, dec_fence, dec_system, dec_error;
  logic [1:0]  trap_cause;

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction model: one instruction in flight, either awaiting issue or awaiting completion.
  bit          m_have;
  bit          m_wait;
  int          m_cls;
  int          m_cnt;
  logic [31:0] m_word;

  logic [31:0] words [10];

  always #5 clk = ~clk;

  issue_sequencer #(
    .MAX_MEM_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .inst_ready (inst_ready),
    .dec_input  (dec_input),
    .dec_enable (dec_enable),
    .dec_alu    (dec_alu),
    .dec_control(dec_control),
    .dec_mem    (dec_mem),
    .dec_fence  (dec_fence),
    .dec_system (dec_system),
    .dec_error  (dec_error),
    .issue_inst (issue_inst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .br_valid   (br_valid),
    .br_ready   (br_ready),
    .br_done    (br_done),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_done   (lsu_done),
    .trap_req   (trap_req),
    .trap_cause (trap_cause),
    .trap_ack   (trap_ack),
    .busy       (busy)
  );

  // Stand-in decoder; JAL and FENCE raise two class bits to exercise the priority order.
  always_comb begin
    dec_alu = 1'b0; dec_control = 1'b0; dec_mem = 1'b0;
    dec_fence = 1'b0; dec_system = 1'b0; dec_error = 1'b0;
    if (dec_enable) begin
      case (dec_input[6:0])
        OPC_OP, OPC_OP_IMM:  dec_alu = 1'b1;
        OPC_LOAD, OPC_STORE: dec_mem = 1'b1;
        OPC_BRANCH:          dec_control = 1'b1;
        OPC_JAL:             begin dec_control = 1'b1; dec_alu = 1'b1; end
        OPC_MISC_MEM:        begin dec_fence = 1'b1; dec_mem = 1'b1; end
        OPC_SYSTEM:          dec_system = 1'b1;
        7'b0000000:          dec_error = 1'b1;
        default:             ;
      endcase
    end
  end

  function automatic int classify(input logic [31:0] w);
    case (w[6:0])
      OPC_OP, OPC_OP_IMM:  return K_ALU;
      OPC_LOAD, OPC_STORE: return K_MEM;
      OPC_BRANCH, OPC_JAL: return K_BR;
      OPC_MISC_MEM:        return K_FENCE;
      OPC_SYSTEM:          return K_SYS;
      default:             return K_ILL;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_have = 0; m_wait = 0; m_cls = K_ALU; m_cnt = 0; m_word = '0;
  endtask

  // Called at a falling edge with inputs already applied; checks outputs, advances the model.
  task automatic tick();
    bit   e_en, e_lsu, e_trap, hs, done_eff;
    logic [1:0] e_cause;
    int   old_cnt;
    #1;
    if (rst) model_reset();
    e_en    = m_have && !m_wait;
    e_lsu   = e_en && m_cls == K_MEM && m_cnt < MAX_OUT;
    e_trap  = m_have && (m_cls == K_SYS || m_cls == K_ILL);
    e_cause = !e_trap ? TRAP_NONE : (m_cls == K_ILL ? TRAP_ILLEGAL : TRAP_SYSTEM);
    check_eq("inst_ready", inst_ready, !rst && !m_have);
    check_eq("dec_enable", dec_enable, e_en);
    check_eq("dec_input", dec_input, m_word);
    check_eq("issue_inst", issue_inst, m_word);
    check_eq("alu_valid", alu_valid, e_en && m_cls == K_ALU);
    check_eq("br_valid", br_valid, e_en && m_cls == K_BR);
    check_eq("lsu_valid", lsu_valid, e_lsu);
    check_eq("trap_req", trap_req, e_trap);
    check_eq("trap_cause", trap_cause, e_cause);
    check_eq("busy", busy, m_have || m_cnt != 0);
    if (!rst) begin
      hs       = e_lsu && lsu_ready;
      old_cnt  = m_cnt;
      done_eff = lsu_done && old_cnt > 0;
      if (!m_have) begin
        if (inst_valid) begin
          m_have = 1; m_wait = 0; m_word = inst_data; m_cls = classify(inst_data);
        end
      end else if (!m_wait) begin
        case (m_cls)
          K_ALU:   if (alu_ready) m_have = 0;
          K_BR:    if (br_ready) m_wait = 1;
          K_MEM:   if (hs) m_have = 0;
          default: m_wait = 1;
        endcase
      end else begin
        case (m_cls)
          K_BR:    if (br_done) m_have = 0;
          K_FENCE: if (old_cnt == 0) m_have = 0;
          default: if (trap_ack) m_have = 0;
        endcase
      end
      m_cnt = old_cnt + int'(hs) - int'(done_eff);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit iv, input logic [31:0] d, input bit ar, input bit brr,
                       input bit brd, input bit lr, input bit ld, input bit ta);
    inst_valid = iv; inst_data = d; alu_ready = ar; br_ready = brr;
    br_done = brd; lsu_ready = lr; lsu_done = ld; trap_ack = ta;
    tick();
  endtask

  initial begin
    words = '{W_ADDI, W_ADD, W_BEQ, W_JAL, W_LW, W_SW, W_FENCE, W_ECALL, W_ZERO, W_ONES};
    model_reset();
    rst = 1'b1;
    inst_valid = 0; inst_data = '0; alu_ready = 0; br_ready = 0; br_done = 0;
    lsu_ready = 0; lsu_done = 0; trap_ack = 0;
    @(negedge clk);
    drive(1, W_ADDI, 1, 1, 1, 1, 1, 1);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // ADDI with ALU always ready
    drive(1, W_ADDI, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);

    // BEQ, br_done five cycles after the branch handshake
    drive(1, W_BEQ, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Four LW fill the window, the fifth stalls until one completes
    repeat (4) begin
      drive(1, W_LW, 0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 0, 0);
    end
    drive(1, W_LW, 0, 0, 0, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    while (m_cnt > 0) drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // FENCE behind two outstanding loads
    repeat (2) begin
      drive(1, W_LW, 0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 0, 0);
    end
    drive(1, W_FENCE, 0, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Fence with nothing outstanding; ECALL and all-zero word trap
    drive(1, W_FENCE, 0, 0, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, W_ECALL, 0, 0, 0, 0, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, W_ZERO, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, W_ONES, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);

    // Stray completions and acks while idle are ignored
    drive(0, 0, 1, 1, 1, 1, 1, 1);

    // Reset while waiting on a branch with two loads outstanding
    repeat (2) begin
      drive(1, W_SW, 0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 0, 0);
    end
    drive(1, W_JAL, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    repeat (4000) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 1), words[$urandom_range(0, 9)],
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 6, m_cnt > 0 && $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
